// File: rtl/spi_irq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : spi_irq_pkg                                                 |
// | Brief  : Shared state encoding and cause-code layout for the SPI     |
// |          interrupt scheduler.                                        |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package spi_irq_pkg;

    typedef enum logic [1:0] {
        S_Idle    = 2'd0,
        S_Assert  = 2'd1,
        S_WaitAck = 2'd2,
        S_Gap     = 2'd3
    } irq_state_t;

    localparam logic [6:0] c_DEFAULT_ACK_ADDR = 7'h20;

    localparam int c_CAUSE_VALID_BIT = 7;
    localparam int c_CAUSE_IDX_MSB   = 2;
    localparam int c_CAUSE_IDX_LSB   = 0;

    function automatic logic [7:0] make_cause(input logic [2:0] idx);
        logic [7:0] c;
        c = 8'h00;
        c[c_CAUSE_VALID_BIT] = 1'b1;
        c[c_CAUSE_IDX_MSB:c_CAUSE_IDX_LSB] = idx;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rr_arbiter                                                  |
// | Brief  : Combinational round-robin pick: first requester at or after |
// |          ptr, wrapping modulo N_SRC.                                 |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    input  logic [2:0]       ptr,
    output logic [2:0]       idx,
    output logic             valid
);

    int w_best;
    int w_dist;

    // Winner is the requester with the smallest forward distance from ptr.
    always_comb begin
        idx    = 3'd0;
        valid  = 1'b0;
        w_best = N_SRC;
        w_dist = 0;
        for (int i = 0; i < N_SRC; i++) begin
            w_dist = i - int'(ptr);
            if (w_dist < 0) w_dist = w_dist + N_SRC;
            if (req[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                idx    = 3'(i);
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_irq_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : spi_irq_scheduler                                           |
// | Brief  : Latches event edges as pending causes, arbitrates them      |
// |          round-robin and runs the host irq pulse/ack handshake.      |
// |          Define IRQ_RETRIGGER_EN to re-pulse after TIMEOUT cycles     |
// |          without an ack.                                             |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module spi_irq_scheduler
    import spi_irq_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [6:0] ACK_ADDR  = c_DEFAULT_ACK_ADDR,
    parameter int         PULSE_LEN = 4,
    parameter int         GAP_LEN   = 2,
    parameter int         TIMEOUT   = 1000
) (
    input  logic             theClock,
    input  logic             theReset,
    input  logic [N_SRC-1:0] ev_in,
    input  logic [N_SRC-1:0] irq_mask,
    input  logic             spi_wr,
    input  logic [6:0]       spi_addr,
    input  logic [7:0]       spi_wdata,
    output logic [N_SRC-1:0] pending,
    output logic [7:0]       cause,
    output logic             irq
);

    localparam int c_MAX_LEN = (PULSE_LEN > GAP_LEN) ?
                               ((PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT) :
                               ((GAP_LEN > TIMEOUT) ? GAP_LEN : TIMEOUT);
    localparam int CNT_W = $clog2(c_MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] c_PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] c_GAP_LOAD   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       c_LAST_IDX   = 3'(N_SRC - 1);

    irq_state_t       r_state, w_state_nxt;
    logic [N_SRC-1:0] r_ev_prev;
    logic [N_SRC-1:0] r_pending;
    logic [7:0]       r_cause, w_cause_nxt;
    logic [2:0]       r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_clr;
    logic [N_SRC-1:0] w_eligible;
    logic [N_SRC-1:0] w_cur_bit;
    logic [2:0]       w_cur_idx;
    logic             w_ack_hit;
    logic             w_cur_acked;
    logic             w_cur_gone;
    logic [2:0]       w_arb_idx;
    logic             w_arb_valid;

    assign w_rise      = ev_in & ~r_ev_prev;
    assign w_ack_hit   = spi_wr && (spi_addr == ACK_ADDR);
    assign w_clr       = w_ack_hit ? spi_wdata[N_SRC-1:0] : '0;
    assign w_eligible  = r_pending & irq_mask;
    assign w_cur_idx   = r_cause[c_CAUSE_IDX_MSB:c_CAUSE_IDX_LSB];
    assign w_cur_bit   = N_SRC'(1) << w_cur_idx;
    assign w_cur_acked = |(w_clr & w_cur_bit);
    // Covers a cause bit already acked during the pulse itself.
    assign w_cur_gone  = ~|(r_pending & w_cur_bit);

    rr_arbiter #(
        .N_SRC (N_SRC)
    ) u_arb (
        .req   (w_eligible),
        .ptr   (r_rr_ptr),
        .idx   (w_arb_idx),
        .valid (w_arb_valid)
    );

`ifdef IRQ_RETRIGGER_EN
    localparam logic [CNT_W-1:0] c_TMO_LOAD = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] r_tmo, w_tmo_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        w_rr_nxt    = r_rr_ptr;
`ifdef IRQ_RETRIGGER_EN
        w_tmo_nxt   = r_tmo;
`endif
        unique case (r_state)
            S_Idle: begin
                if (w_arb_valid) begin
                    w_cause_nxt = make_cause(w_arb_idx);
                    w_cnt_nxt   = c_PULSE_LOAD;
                    w_state_nxt = S_Assert;
                end
            end
            S_Assert: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WaitAck;
`ifdef IRQ_RETRIGGER_EN
                    w_tmo_nxt   = c_TMO_LOAD;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            S_WaitAck: begin
                if (w_cur_acked || w_cur_gone) begin
                    w_rr_nxt    = (w_cur_idx == c_LAST_IDX) ? 3'd0 : w_cur_idx + 3'd1;
                    w_cause_nxt = 8'h00;
                    w_cnt_nxt   = c_GAP_LOAD;
                    w_state_nxt = S_Gap;
                end
`ifdef IRQ_RETRIGGER_EN
                else if (r_tmo == '0) begin
                    w_cnt_nxt   = c_PULSE_LOAD;
                    w_state_nxt = S_Assert;
                end else begin
                    w_tmo_nxt = r_tmo - c_CNT_ONE;
                end
`endif
            end
            S_Gap: begin
                if (r_cnt == '0) w_state_nxt = S_Idle;
                else             w_cnt_nxt   = r_cnt - c_CNT_ONE;
            end
            default: w_state_nxt = S_Idle;
        endcase
    end

    always_ff @(posedge theClock) begin
        r_ev_prev <= ev_in;
        if (!theReset) begin
            r_state   <= S_Idle;
            r_pending <= '0;
            r_cause   <= 8'h00;
            r_rr_ptr  <= 3'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            // Set beats clear when an edge and an ack hit the same bit.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_cause   <= w_cause_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

`ifdef IRQ_RETRIGGER_EN
    always_ff @(posedge theClock) begin
        if (!theReset) r_tmo <= '0;
        else           r_tmo <= w_tmo_nxt;
    end
`endif

    assign pending = r_pending;
    assign cause   = r_cause;
    assign irq     = (r_state == S_Assert);

endmodule
`default_nettype wire

// File: tb/tb_spi_irq_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_spi_irq_scheduler                                        |
// | Brief  : Self-checking bench; expected irq causes are queued as      |
// |          events are driven and popped as each irq pulse completes.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_spi_irq_scheduler;

    localparam int         N_SRC     = 8;
    localparam logic [6:0] ACK_ADDR  = 7'h20;
    localparam int         PULSE_LEN = 4;
    localparam int         GAP_LEN   = 2;
    localparam int         TIMEOUT   = 20;

    logic             theClock = 1'b0;
    logic             theReset = 1'b0;
    logic [N_SRC-1:0] ev_in    = '0;
    logic [N_SRC-1:0] irq_mask = '0;
    logic             spi_wr   = 1'b0;
    logic [6:0]       spi_addr = '0;
    logic [7:0]       spi_wdata = '0;
    logic [N_SRC-1:0] pending;
    logic [7:0]       cause;
    logic             irq;

    int        n_cmp = 0;
    int        n_err = 0;
    int        cyc = 0;
    int        n_pulses = 0;
    logic [7:0] exp_q[$];

    spi_irq_scheduler #(
        .N_SRC     (N_SRC),
        .ACK_ADDR  (ACK_ADDR),
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .theClock  (theClock),
        .theReset  (theReset),
        .ev_in     (ev_in),
        .irq_mask  (irq_mask),
        .spi_wr    (spi_wr),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .pending   (pending),
        .cause     (cause),
        .irq       (irq)
    );

    always #5 theClock = ~theClock;
    always @(posedge theClock) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: each completed irq pulse is scored against the queue.
    logic       irq_d = 1'b0;
    logic [7:0] pulse_cause = 8'h00;
    int         pulse_len = 0;
    always @(negedge theClock) begin
        logic [7:0] exp_c;
        if (irq && !irq_d) begin
            pulse_cause = cause;
            pulse_len   = 1;
        end else if (irq) begin
            pulse_len++;
        end
        if (!irq && irq_d) begin
            exp_c = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            chk("pulse_cause", 32'(pulse_cause), 32'(exp_c));
            chk("pulse_len", pulse_len, PULSE_LEN);
            n_pulses++;
        end
        irq_d = irq;
    end

    task automatic step();
        @(posedge theClock);
        #1;
    endtask

    task automatic do_reset();
        step();
        theReset = 1'b0;
        step();
        step();
        theReset = 1'b1;
    endtask

    task automatic pulse_ev(input int b);
        step();
        ev_in[b] = 1'b1;
        step();
        ev_in[b] = 1'b0;
    endtask

    task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
        step();
        spi_addr  = a;
        spi_wdata = d;
        spi_wr    = 1'b1;
        step();
        spi_wr    = 1'b0;
        spi_wdata = 8'h00;
    endtask

    task automatic wait_pulse_done();
        bit seen_hi = 0;
        bit seen_lo = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge theClock);
            if (irq) begin seen_hi = 1; break; end
        end
        chk("irq_rise_seen", 32'(seen_hi), 1);
        for (int k = 0; k < 60; k++) begin
            @(negedge theClock);
            if (!irq) begin seen_lo = 1; break; end
        end
        chk("irq_fall_seen", 32'(seen_lo), 1);
    endtask

    task automatic wait_rise(output int c);
        bit ok = 0;
        c = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge theClock);
            if (!irq) break;
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge theClock);
            if (irq) begin ok = 1; c = cyc; break; end
        end
        chk("irq_rise_found", 32'(ok), 1);
    endtask

    initial begin
        int c0, c1, base;
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, base;
        // Reset with a level already high: not an event after release.
        ev_in    = 8'h01;
        irq_mask = 8'hFF;
        repeat (3) step();
        @(negedge theClock);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_cause", 32'(cause), 0);
        chk("rst_irq", 32'(irq), 0);
        step();
        theReset = 1'b1;
        repeat (5) step();
        @(negedge theClock);
        chk("held_lvl_pending", 32'(pending), 0);
        chk("held_lvl_irq", 32'(irq), 0);
        step();
        ev_in = 8'h00;

        // Single event on bit 3, with latency checks.
        exp_q.push_back(8'h83);
        pulse_ev(3);
        @(negedge theClock);
        chk("ev3_pending", 32'(pending), 32'h08);
        chk("ev3_irq_t1", 32'(irq), 0);
        @(negedge theClock);
        chk("ev3_irq_t2", 32'(irq), 1);
        chk("ev3_cause", 32'(cause), 32'h83);
        wait_pulse_done();
        chk("ev3_cause_held", 32'(cause), 32'h83);
        spi_write(ACK_ADDR, 8'h08);
        @(negedge theClock);
        chk("ev3_ack_pending", 32'(pending), 0);
        chk("ev3_ack_cause", 32'(cause), 0);

        // Two simultaneous events, round-robin from pointer 0.
        do_reset();
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h85);
        step();
        ev_in = 8'h22;
        step();
        ev_in = 8'h00;
        wait_pulse_done();
        chk("rr_cause1", 32'(cause), 32'h81);
        chk("rr_pending", 32'(pending), 32'h22);
        spi_write(7'h21, 8'h22);
        @(negedge theClock);
        chk("other_addr_ignored", 32'(pending), 32'h22);
        spi_write(ACK_ADDR, 8'h00);
        @(negedge theClock);
        chk("zero_ack_noop", 32'(pending), 32'h22);
        spi_write(ACK_ADDR, 8'h02);
        @(negedge theClock);
        chk("rr_ack1_pending", 32'(pending), 32'h20);
        chk("rr_ack1_cause", 32'(cause), 0);
        chk("rr_gap_irq", 32'(irq), 0);
        wait_pulse_done();
        chk("rr_cause2", 32'(cause), 32'h85);
        spi_write(ACK_ADDR, 8'h20);
        @(negedge theClock);
        chk("rr_ack2_pending", 32'(pending), 0);
        repeat (6) @(negedge theClock);
        chk("rr_idle_irq", 32'(irq), 0);
        chk("rr_idle_cause", 32'(cause), 0);

        // Masked source latches but does not interrupt until unmasked.
        do_reset();
        irq_mask = 8'h00;
        pulse_ev(2);
        repeat (6) @(negedge theClock);
        chk("masked_pending", 32'(pending), 32'h04);
        chk("masked_irq", 32'(irq), 0);
        exp_q.push_back(8'h82);
        step();
        irq_mask = 8'h04;
        wait_pulse_done();
        chk("unmasked_cause", 32'(cause), 32'h82);
        spi_write(ACK_ADDR, 8'h04);
        irq_mask = 8'hFF;

        // Ack coinciding with a new rise on the same bit: set wins.
        exp_q.push_back(8'h83);
        pulse_ev(3);
        wait_pulse_done();
        exp_q.push_back(8'h83);
        step();
        ev_in[3]  = 1'b1;
        spi_addr  = ACK_ADDR;
        spi_wdata = 8'h08;
        spi_wr    = 1'b1;
        step();
        ev_in     = 8'h00;
        spi_wr    = 1'b0;
        spi_wdata = 8'h00;
        @(negedge theClock);
        chk("setwins_pending", 32'(pending), 32'h08);
        chk("setwins_gap_irq", 32'(irq), 0);
        wait_pulse_done();
        spi_write(ACK_ADDR, 8'h08);
        @(negedge theClock);
        chk("setwins_cleared", 32'(pending), 0);

        // No ack: re-pulse on timeout only when the feature is built in.
`ifdef IRQ_RETRIGGER_EN
        exp_q.push_back(8'h86);
        exp_q.push_back(8'h86);
        pulse_ev(6);
        wait_rise(c0);
        wait_rise(c1);
        chk("retrig_period", c1 - c0, PULSE_LEN + TIMEOUT);
        wait_pulse_done();
`else
        exp_q.push_back(8'h86);
        base = n_pulses;
        pulse_ev(6);
        wait_pulse_done();
        repeat (60) @(negedge theClock);
        chk("single_pulse", n_pulses - base, 1);
`endif
        spi_write(ACK_ADDR, 8'h40);
        repeat (6) @(negedge theClock);
        chk("final_pending", 32'(pending), 0);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_irq_scheduler.md
Name: spi_irq_scheduler

Overview:
- Collects event strobes from the FPGA-side game and display logic and latches them as pending interrupt causes.
- Arbitrates pending causes round-robin and presents one cause code to the SPI register file for the host to read.
- Sequences the host interrupt line through a pulse/acknowledge handshake.
- The host acknowledges by an SPI write to the ack register; the write-commit strobe comes from the SPI slave.

Parameters:
- N_SRC, 8, number of event sources (1..8)
- ACK_ADDR, 7'h20, SPI register address whose write clears pending bits
- PULSE_LEN, 4, irq high time in theClock cycles (>=1)
- GAP_LEN, 2, minimum irq low time after an ack before the next pulse (>=1)
- TIMEOUT, 1000, cycles to wait for an ack before re-pulsing (only with IRQ_RETRIGGER_EN)

Ports:
- theClock  in  1  system clock
- theReset  in  1  synchronous reset, active-low
- ev_in  in  N_SRC  event levels/strobes; rising edge = event
- irq_mask  in  N_SRC  1 = source may raise irq (driven from Config)
- spi_wr  in  1  one-cycle strobe, SPI host write committed
- spi_addr  in  7  address of committed write
- spi_wdata  in  8  data of committed write
- pending  out  N_SRC  latched pending bits
- cause  out  8  {valid, 4'b0, idx[2:0]}; 8'h00 when none
- irq  out  1  interrupt line to host

Behaviour:
- Reset (theReset=0 at a theClock edge):
  - pending=0, cause=8'h00, irq=0, rr_ptr=0, state=S_Idle, counters=0.
  - ev_prev<=ev_in, so levels already high at reset release are not events.
- Edge detect: rise[i] = ev_in[i] & ~ev_prev[i]; ev_prev registered every cycle.
- Pending latching:
  - pending[i] sets on rise[i], regardless of the mask.
  - pending[i] clears when spi_wr & spi_addr==ACK_ADDR & spi_wdata[i]=1.
  - If rise and clear coincide on the same bit, set wins.
- Eligible = pending & irq_mask.
- Arbiter: round-robin search starting at rr_ptr, wrapping modulo N_SRC; the first eligible index wins.
- cause updates only on the S_Idle->S_Assert transition and is held stable until the next selection.
- FSM:
  - S_Idle: irq=0. If |eligible: latch cause, load cnt=PULSE_LEN-1, go to S_Assert.
  - S_Assert: irq=1, cnt decrements. At cnt==0, go to S_WaitAck.
  - S_WaitAck: irq=0.
    - An ack write clearing bit cause.idx: rr_ptr<=idx+1 (wraps), cause=8'h00, load cnt=GAP_LEN-1, go to S_Gap.
    - An ack write clearing only other bits: clear those bits, stay in S_WaitAck.
    - A mask change does not exit S_WaitAck.
  - S_Gap: irq=0, cnt decrements. At cnt==0, go to S_Idle.
- Latency:
  - Event edge at cycle t: pending visible at t+1, irq high at t+2 when in S_Idle.
  - Ack commit at cycle t: pending clear at t+1.
- Ack in S_Assert or S_Gap: clears pending bits only, no state change. If the current cause bit is acked in S_Assert, finish the pulse, then S_WaitAck exits at once via S_Gap.
- Ack writing 0s is a no-op. Writes to other addresses are ignored.
- Reset mid-pulse drops irq on the next edge.
- Counter width: clog2 of the largest of PULSE_LEN, GAP_LEN, TIMEOUT, plus 1.

Optional Feature:
- Macro: IRQ_RETRIGGER_EN.
- Defined:
  - A timeout counter runs in S_WaitAck.
  - After TIMEOUT cycles without an ack of cause.idx, return to S_Assert with the same cause.
  - The pulse counter reloads; the timeout counter reloads on every S_WaitAck entry.
- Undefined: S_WaitAck waits indefinitely; no timeout logic is synthesised.

Decomposition:
- Shared package spi_irq_pkg:
  - state typedef {S_Idle, S_Assert, S_WaitAck, S_Gap}
  - default ACK_ADDR constant
  - cause-code field positions (valid bit 7, idx bits 2:0)
- One sub-module, rr_arbiter: combinational request vector plus rr_ptr in, index and valid out.

Test Plan:
- Reset release with ev_in=8'h01 held high -> pending stays 0, irq stays 0.
- irq_mask=8'hFF, pulse ev_in[3] -> pending=8'h08, cause=8'h83, irq high exactly 4 cycles, then low.
- ev_in[1] and ev_in[5] rise together, rr_ptr=0 -> cause=8'h81 first. Ack 8'h02 -> after 2-cycle gap, cause=8'h85. Ack 8'h20 -> pending=0, irq idle.
- irq_mask=8'h00, event on bit 2 -> pending=8'h04, no irq. Set mask to 8'h04 -> irq pulse with cause=8'h82.
- Ack write to bit 3 in the same cycle as a new rise on bit 3 -> pending[3] remains 1, a second irq pulse follows after the gap.
- With IRQ_RETRIGGER_EN, TIMEOUT=20, no ack -> irq re-pulses every 4+20 cycles with unchanged cause. Without the macro -> a single pulse only.
